// File: rtl/store_stage.sv
// store_stage: serializes a squeezed rate block into W-bit ready/valid words, tracking the owed output length.
// Optional STORE_STAGE_TAIL_MASK_EN zeroes the unused high bits of a partial final word.
module store_stage #(
  parameter int W        = 64,
  parameter int RATE_MAX = 1344
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RATE_MAX-1:0] rate_output,
  input  logic                output_buffer_we,
  input  logic [31:0]         output_size,
  input  logic [1:0]          operation_mode,
  input  logic                copy_control_regs_en,
  output logic                output_buffer_ready,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [W-1:0]        data_out,
  output logic                last_o
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam int LW = $clog2(W);
  logic [0:0]          state_q, state_d;
  logic [RATE_MAX-1:0] sr_q, sr_d;
  logic [31:0]         rem_q, rem_d;
  logic [4:0]          wpb_q, wpb_d;
  logic [4:0]          idx_q, idx_d;
  logic                done;
  assign done = rem_q <= 32'(W);
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    rem_d   = rem_q;
    wpb_d   = wpb_q;
    idx_d   = idx_q;
    if (state_q == EMPTY) begin
      if (copy_control_regs_en) begin
        rem_d = output_size;
        wpb_d = operation_mode == 2'b00 ? 5'd21 : 5'd17;
      end
      if (output_buffer_we && rem_q != '0) begin
        sr_d    = rate_output;
        idx_d   = '0;
        state_d = DRAIN;
      end
    end else if (ready_i) begin
      sr_d    = sr_q >> W;
      idx_d   = idx_q + 5'd1;
      rem_d   = done ? '0 : rem_q - 32'(W);
      state_d = (done || idx_q == wpb_q - 5'd1) ? EMPTY : DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      sr_q    <= '0;
      rem_q   <= '0;
      wpb_q   <= 5'd21;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      wpb_q   <= wpb_d;
      idx_q   <= idx_d;
    end
  end
  assign output_buffer_ready = state_q == EMPTY;
  assign valid_o             = state_q == DRAIN;
  assign last_o              = valid_o && done;
`ifdef STORE_STAGE_TAIL_MASK_EN
  // remaining is never 0 while draining, so a shift of rem_q[LW-1:0] keeps at least one bit
  assign data_out = rem_q < 32'(W) ? sr_q[W-1:0] & ~({W{1'b1}} << rem_q[LW-1:0]) : sr_q[W-1:0];
`else
  assign data_out = sr_q[W-1:0];
`endif
endmodule

// File: tb/tb_store_stage.sv
// tb_store_stage: randomized and directed checks of store_stage against a per-message word-list model.
module tb_store_stage;
  localparam int W = 64;
  localparam int RATE_MAX = 1344;
  logic                clk = 1'b0;
  logic                rst;
  logic [RATE_MAX-1:0] rate_output;
  logic                output_buffer_we;
  logic [31:0]         output_size;
  logic [1:0]          operation_mode;
  logic                copy_control_regs_en;
  logic                output_buffer_ready;
  logic                ready_i;
  logic                valid_o;
  logic [W-1:0]        data_out;
  logic                last_o;
  int n_cmp = 0;
  int n_bad = 0;
  int m_rem = 0;
  int m_wpb = 21;
  bit pat [6] = '{1, 0, 0, 1, 0, 1};
  logic [RATE_MAX-1:0] cnt_blk, b;

  store_stage #(.W(W), .RATE_MAX(RATE_MAX)) dut (
    .clk(clk), .rst(rst), .rate_output(rate_output), .output_buffer_we(output_buffer_we),
    .output_size(output_size), .operation_mode(operation_mode),
    .copy_control_regs_en(copy_control_regs_en), .output_buffer_ready(output_buffer_ready),
    .ready_i(ready_i), .valid_o(valid_o), .data_out(data_out), .last_o(last_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int size, input logic [1:0] mode);
    copy_control_regs_en = 1'b1;
    output_size = size;
    operation_mode = mode;
    step();
    copy_control_regs_en = 1'b0;
    m_rem = size;
    m_wpb = mode == 2'b00 ? 21 : 17;
  endtask

  function automatic logic [RATE_MAX-1:0] rand_blk();
    logic [RATE_MAX-1:0] r;
    for (int k = 0; k < RATE_MAX / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // rm: 0 = always ready, 1 = random ready, 2 = fixed stall pattern; inj pokes DRAIN with we/copy noise
  task automatic send_block(input logic [RATE_MAX-1:0] blk, input int rm, input bit inj);
    logic [63:0] ew[$];
    bit el[$];
    logic [63:0] wd;
    int r, got, cyc;
    r = m_rem;
    for (int k = 0; k < m_wpb && r > 0; k++) begin
      wd = blk[k*W +: W];
`ifdef STORE_STAGE_TAIL_MASK_EN
      if (r < W) wd = wd & ((64'd1 << r) - 64'd1);
`endif
      ew.push_back(wd);
      el.push_back(r <= W);
      r = r > W ? r - W : 0;
    end
    m_rem = r;
    @(negedge clk);
    chk("obr_pre", output_buffer_ready, 1);
    step();
    rate_output = blk;
    output_buffer_we = 1'b1;
    step();
    output_buffer_we = 1'b0;
    got = 0;
    cyc = 0;
    while (got < ew.size() && cyc < 400) begin
      ready_i = rm == 0 ? 1'b1 : rm == 1 ? 1'($urandom_range(0, 1)) : pat[cyc % 6];
      if (inj) begin
        output_buffer_we = 1'($urandom_range(0, 1));
        rate_output = ~blk;
        copy_control_regs_en = 1'($urandom_range(0, 1));
        output_size = 64;
        operation_mode = 2'b00;
      end
      @(negedge clk);
      chk("valid", valid_o, 1);
      chk(ready_i ? "data" : "hold", data_out, ew[got]);
      chk("last", last_o, el[got]);
      chk("obr_busy", output_buffer_ready, 0);
      if (ready_i) got++;
      step();
      cyc++;
    end
    ready_i = 1'b0;
    output_buffer_we = 1'b0;
    copy_control_regs_en = 1'b0;
    if (got < ew.size()) chk("timeout", got, ew.size());
    @(negedge clk);
    chk("idle_valid", valid_o, 0);
    chk("idle_obr", output_buffer_ready, 1);
    chk("idle_last", last_o, 0);
  endtask

  initial begin
    for (int k = 0; k < 21; k++) cnt_blk[k*W +: W] = 64'h1000 + k;
    rst = 1'b1;
    rate_output = '0;
    output_buffer_we = 1'b0;
    output_size = '0;
    operation_mode = '0;
    copy_control_regs_en = 1'b0;
    ready_i = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_data", data_out, 0);
    chk("rst_obr", output_buffer_ready, 1);
    step();
    cfg(256, 2'b00);
    send_block(cnt_blk, 0, 0);
    send_block(cnt_blk, 0, 0);
    cfg(1152, 2'b01);
    send_block(rand_blk(), 0, 0);
    send_block(rand_blk(), 0, 0);
    cfg(21 * 64, 2'b00);
    send_block(cnt_blk, 2, 0);
    cfg(100, 2'b00);
    b = cnt_blk;
    b[127:64] = '1;
    send_block(b, 0, 0);
    cfg(640, 2'b00);
    rate_output = cnt_blk;
    output_buffer_we = 1'b1;
    step();
    output_buffer_we = 1'b0;
    ready_i = 1'b1;
    step();
    @(negedge clk);
    chk("pre_rst_data", data_out, 64'h1001);
    step();
    rst = 1'b1;
    ready_i = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_last", last_o, 0);
    chk("mid_rst_obr", output_buffer_ready, 1);
    m_rem = 0;
    send_block(cnt_blk, 0, 0);
    cfg(640, 2'b01);
    send_block(rand_blk(), 1, 1);
    repeat (6) begin
      cfg($urandom_range(1, 3000), 2'($urandom_range(0, 3)));
      while (m_rem > 0) send_block(rand_blk(), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
